control_encode: RTL and testbench

Control FSM for the QC-LDPC encoder, the transmit-side counterpart of the NMS decoder control path. It sequences a systematic quasi-cyclic encoder datapath: it clears the parity accumulators, accepts KB message words of Z bits each, and drives Z rotate-accumulate cycles per word. It then streams the KB systematic words and MB parity words to the downstream consumer, and pulses `finish_enc` when the codeword is out. It owns all counters; the datapath (message RAM, barrel rotator, parity XOR accumulators) is purely slave to its strobes.

---
 rtl/enc_pkg.sv | 27 ++
 rtl/enc_counter.sv | 40 ++++
 rtl/control_encode.sv | 127 ++++++++++++
 tb/tb_control_encode.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants for the QC-LDPC encoder: FSM state encoding, default code
// geometry and the counter-width helpers used by the controller, datapath and bench.
package enc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        ACC   = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int Z_DEF  = 16;
    localparam int KB_DEF = 4;
    localparam int MB_DEF = 4;

    // Widths are floored at 1 so a degenerate geometry still yields a legal vector.
    function automatic int IDX_W(input int kb, input int mb);
        return (kb + mb > 1) ? $clog2(kb + mb) : 1;
    endfunction

    function automatic int SH_W(input int z);
        return (z > 1) ? $clog2(z) : 1;
    endfunction

endpackage

// File: rtl/enc_counter.sv
// Mod-N up-counter with synchronous clear and a terminal-count flag; clear
// wins over increment, and the count wraps to zero after N-1.
module enc_counter #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/control_encode.sv
// Control FSM for the systematic QC-LDPC encoder: clears the parity accumulators,
// loads KB message words, drives Z rotate-accumulate cycles per word, then streams the codeword.
module control_encode
    import enc_pkg::*;
#(
    parameter int  Z  = Z_DEF,
    parameter int  KB = KB_DEF,
    parameter int  MB = MB_DEF,
    localparam int IW = IDX_W(KB, MB),
    localparam int SW = SH_W(Z)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_enc,
    input  logic          abort,
    input  logic          msg_valid,
    output logic          msg_ready,
    output logic          en_load,
    output logic          rst_acc,
    output logic          en_acc,
    output logic [IW-1:0] col_idx,
    output logic [SW-1:0] shift_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sel,
    output logic          busy,
    output logic          finish_enc
);

    localparam logic [IW-1:0] LAST_MSG_COL = IW'(KB - 1);
    localparam logic [IW-1:0] FIRST_PAR    = IW'(KB);

    state_e state_q;
    state_e state_d;

    logic sh_clr, sh_inc, sh_tc;
    logic ix_clr, ix_inc, ix_tc;

    enc_counter #(.N(Z), .W(SW)) u_shift_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (sh_clr),
        .inc_i (sh_inc),
        .cnt_o (shift_cnt),
        .tc_o  (sh_tc)
    );

    // Index counter doubles as message column (LOAD/ACC) and output word index (OUT).
    enc_counter #(.N(KB + MB), .W(IW)) u_index_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (ix_clr),
        .inc_i (ix_inc),
        .cnt_o (col_idx),
        .tc_o  (ix_tc)
    );

    always_comb begin
        state_d = state_q;
        sh_clr  = 1'b0;
        sh_inc  = 1'b0;
        ix_clr  = 1'b0;
        ix_inc  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            sh_clr  = 1'b1;
            ix_clr  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_enc) state_d = CLEAR;
                end
                CLEAR: begin
                    sh_clr  = 1'b1;
                    ix_clr  = 1'b1;
                    state_d = LOAD;
                end
                LOAD: begin
                    if (msg_valid) state_d = ACC;
                end
                ACC: begin
                    sh_inc = 1'b1;
                    if (sh_tc) begin
                        if (col_idx == LAST_MSG_COL) begin
                            ix_clr  = 1'b1;
                            state_d = OUT;
                        end else begin
                            ix_inc  = 1'b1;
                            state_d = LOAD;
                        end
                    end
                end
                OUT: begin
                    // The index counter wraps to 0 on the final handshake, leaving it clean for DONE.
                    if (out_ready) begin
                        ix_inc = 1'b1;
                        if (ix_tc) state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign msg_ready  = (state_q == LOAD);
    assign en_load    = msg_ready & msg_valid;
    assign rst_acc    = (state_q == CLEAR);
    assign en_acc     = (state_q == ACC);
    assign out_valid  = (state_q == OUT);
    assign out_sel    = out_valid & (col_idx >= FIRST_PAR);
    assign busy       = (state_q != IDLE);
    assign finish_enc = (state_q == DONE);

endmodule

// File: tb/tb_control_encode.sv
// Directed bench for control_encode at the default geometry (Z=16, KB=4, MB=4).
module tb_control_encode;
    import enc_pkg::*;

    localparam int Z  = 16;
    localparam int KB = 4;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_enc = 1'b0;
    logic       abort = 1'b0;
    logic       msg_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       msg_ready, en_load, rst_acc, en_acc, out_valid, out_sel, busy, finish_enc;
    logic [2:0] col_idx;
    logic [3:0] shift_cnt;

    int errors = 0;
    int checks = 0;

    int gap_word;
    int gap_len;
    int or_pat[$];
    bit xstart;

    int n_rst_acc, n_load, n_acc, n_fin, fin_cyc, overlap, gap_ok, out_gap, busy_tail;
    bit busy_c1;
    int hs_cols[$];
    bit hs_sel[$];
    int stall_cols[$];

    control_encode #(.Z(Z), .KB(KB), .MB(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_enc  (start_enc),
        .abort      (abort),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .en_load    (en_load),
        .rst_acc    (rst_acc),
        .en_acc     (en_acc),
        .col_idx    (col_idx),
        .shift_cnt  (shift_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .busy       (busy),
        .finish_enc (finish_enc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycle c=0 is the start_enc cycle; CLEAR is observed at c=1.
    task automatic drive_run(input int maxc, input int tail);
        int  gap_done = 0;
        int  or_k = 0;
        int  c = 0;
        int  tail_left = -1;
        bit  in_out = 0;
        bit  xs_load = 0;
        n_rst_acc = 0; n_load = 0; n_acc = 0; n_fin = 0; fin_cyc = -1;
        overlap = 0; gap_ok = 0; out_gap = 0; busy_tail = 0; busy_c1 = 0;
        hs_cols.delete(); hs_sel.delete(); stall_cols.delete();
        while (c < maxc && tail_left != 0) begin
            @(negedge clk);
            start_enc = (c == 0);
            if (xstart && msg_ready && n_load == 1 && !xs_load) begin
                start_enc = 1'b1;
                xs_load = 1;
            end
            if (xstart && finish_enc) start_enc = 1'b1;
            msg_valid = 1'b1;
            if (msg_ready && n_load == gap_word && gap_done < gap_len) begin
                msg_valid = 1'b0;
                gap_done++;
            end
            out_ready = (or_k < or_pat.size()) ? (or_pat[or_k] != 0) : 1'b1;
            if (out_valid) or_k++;
            #1;
            if (c == 1) busy_c1 = busy;
            n_rst_acc += int'(rst_acc);
            n_load    += int'(en_load);
            n_acc     += int'(en_acc);
            if (en_load && en_acc) overlap++;
            if (rst_acc && en_acc) overlap++;
            if (msg_ready && !msg_valid && !en_acc && !en_load) gap_ok++;
            if (out_valid) in_out = 1;
            if (in_out && hs_cols.size() < KB + MB && !out_valid) out_gap++;
            if (out_valid && out_ready) begin
                hs_cols.push_back(int'(col_idx));
                hs_sel.push_back(out_sel);
            end
            if (out_valid && !out_ready) stall_cols.push_back(int'(col_idx));
            if (finish_enc) begin
                n_fin++;
                if (fin_cyc < 0) begin
                    fin_cyc = c;
                    tail_left = tail + 1;
                end
            end
            if (tail_left > 0) begin
                if (c != fin_cyc && busy) busy_tail++;
                tail_left--;
            end
            c++;
        end
        start_enc = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({msg_ready, en_load, rst_acc, en_acc, out_valid, out_sel, busy, finish_enc} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {msg_ready, en_load, rst_acc, en_acc, out_valid, out_sel, busy, finish_enc});
        end
        checks++;
        if (col_idx !== 3'd0 || shift_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters: got col=%0d shift=%0d expected 0/0", col_idx, shift_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_full_run();
        int bad = 0;
        logic [7:0] sel_v = '0;
        gap_word = -1; gap_len = 0; or_pat.delete(); xstart = 0;
        drive_run(200, 3);
        checks++;
        if (busy_c1 !== 1'b1) begin errors++; $display("FAIL full_busy_c1: got %b expected 1", busy_c1); end
        checks++;
        if (n_rst_acc != 1) begin errors++; $display("FAIL full_rst_acc: got %0d expected 1", n_rst_acc); end
        checks++;
        if (n_load != 4) begin errors++; $display("FAIL full_en_load: got %0d expected 4", n_load); end
        checks++;
        if (n_acc != 64) begin errors++; $display("FAIL full_en_acc: got %0d expected 64", n_acc); end
        for (int i = 0; i < hs_cols.size(); i++) begin
            if (hs_cols[i] != i) bad++;
            if (i < 8) sel_v[i] = hs_sel[i];
        end
        checks++;
        if (hs_cols.size() != 8 || bad != 0) begin
            errors++;
            $display("FAIL full_out_words: got %0d words (%0d out of order) expected 8 in order", hs_cols.size(), bad);
        end
        checks++;
        if (sel_v !== 8'hF0) begin errors++; $display("FAIL full_out_sel: got %b expected 11110000", sel_v); end
        checks++;
        if (fin_cyc != 78) begin errors++; $display("FAIL full_latency: got %0d expected 78", fin_cyc); end
        checks++;
        if (n_fin != 1 || busy_tail != 0) begin
            errors++;
            $display("FAIL full_finish_once: got fin=%0d busy_after=%0d expected 1/0", n_fin, busy_tail);
        end
        checks++;
        if (overlap != 0) begin errors++; $display("FAIL full_strobe_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_msg_stall();
        gap_word = 2; gap_len = 5; or_pat.delete(); xstart = 0;
        drive_run(200, 2);
        checks++;
        if (gap_ok != 5) begin errors++; $display("FAIL stall_wait_cycles: got %0d expected 5", gap_ok); end
        checks++;
        if (n_load != 4 || n_acc != 64) begin
            errors++;
            $display("FAIL stall_counts: got load=%0d acc=%0d expected 4/64", n_load, n_acc);
        end
        checks++;
        if (fin_cyc != 83) begin errors++; $display("FAIL stall_latency: got %0d expected 83", fin_cyc); end
        gap_word = -1; gap_len = 0;
    endtask

    task automatic test_out_backpressure();
        int bad = 0;
        gap_word = -1; gap_len = 0; xstart = 0;
        or_pat = '{1, 0, 0, 1};
        drive_run(200, 2);
        for (int i = 0; i < hs_cols.size(); i++) if (hs_cols[i] != i) bad++;
        checks++;
        if (hs_cols.size() != 8 || bad != 0) begin
            errors++;
            $display("FAIL bp_out_words: got %0d words (%0d out of order) expected 8 in order", hs_cols.size(), bad);
        end
        checks++;
        if (stall_cols.size() != 2 || stall_cols[0] != 1 || stall_cols[stall_cols.size()-1] != 1) begin
            errors++;
            $display("FAIL bp_col_hold: got %0d stall cycles expected 2 holding col 1", stall_cols.size());
        end
        checks++;
        if (out_gap != 0) begin errors++; $display("FAIL bp_valid_drop: got %0d expected 0", out_gap); end
        checks++;
        if (fin_cyc != 80) begin errors++; $display("FAIL bp_latency: got %0d expected 80", fin_cyc); end
        or_pat.delete();
    endtask

    task automatic test_abort();
        bit found = 0;
        int fins = 0;
        int busys = 0;
        @(negedge clk);
        start_enc = 1'b1; msg_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            start_enc = 1'b0;
            #1;
            if (en_acc && col_idx == 3'd2 && shift_cnt == 4'd7) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach: got no ACC col2 shift7 expected reached"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if ({busy, en_acc, col_idx, shift_cnt} !== 9'd0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b acc=%b col=%0d sh=%0d expected all 0", busy, en_acc, col_idx, shift_cnt);
        end
        repeat (100) begin
            @(negedge clk);
            #1;
            fins += int'(finish_enc);
            busys += int'(busy);
        end
        checks++;
        if (fins != 0 || busys != 0) begin
            errors++;
            $display("FAIL abort_no_finish: got fin=%0d busy=%0d expected 0/0", fins, busys);
        end
        gap_word = -1; gap_len = 0; or_pat.delete(); xstart = 0;
        drive_run(200, 2);
        checks++;
        if (fin_cyc != 78 || n_load != 4 || n_fin != 1) begin
            errors++;
            $display("FAIL abort_rerun: got fin_at=%0d loads=%0d fins=%0d expected 78/4/1", fin_cyc, n_load, n_fin);
        end
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        start_enc = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_enc = 1'b0; abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_over_start: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_out();
        bit found = 0;
        int busys = 0;
        @(negedge clk);
        start_enc = 1'b1; msg_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            start_enc = 1'b0;
            #1;
            if (out_valid && col_idx == 3'd5) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_reach: got no OUT col5 expected reached"); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({msg_ready, en_load, rst_acc, en_acc, out_valid, out_sel, busy, finish_enc} !== 8'h00) begin
            errors++;
            $display("FAIL rst_async_outputs: got %b expected 00000000",
                     {msg_ready, en_load, rst_acc, en_acc, out_valid, out_sel, busy, finish_enc});
        end
        checks++;
        if (col_idx !== 3'd0 || shift_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_async_counters: got col=%0d sh=%0d expected 0/0", col_idx, shift_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #1;
            busys += int'(busy);
        end
        checks++;
        if (busys != 0) begin errors++; $display("FAIL rst_idle_after: got %0d busy cycles expected 0", busys); end
    endtask

    task automatic test_start_ignored();
        gap_word = -1; gap_len = 0; or_pat.delete(); xstart = 1;
        drive_run(200, 20);
        checks++;
        if (fin_cyc != 78) begin errors++; $display("FAIL ign_latency: got %0d expected 78", fin_cyc); end
        checks++;
        if (n_fin != 1 || busy_tail != 0) begin
            errors++;
            $display("FAIL ign_single_finish: got fin=%0d busy_after=%0d expected 1/0", n_fin, busy_tail);
        end
        checks++;
        if (n_rst_acc != 1) begin errors++; $display("FAIL ign_rst_acc: got %0d expected 1", n_rst_acc); end
        xstart = 0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_msg_stall();
        test_out_backpressure();
        test_abort();
        test_abort_idle();
        test_reset_mid_out();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
